// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
// State encoding, default result width and oversample depth.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    CONVERT,
    OUTPUT
  } state_t;

  localparam int ADC_DATA_W   = 12;
  localparam int OVERSAMPLE_N = 4;

endpackage

// File: rtl/adc_sample_scheduler_rr_select.sv
// Round-robin finder: nearest set mask bit strictly after ptr.
// Wraps at NUM_CH; ptr itself is checked last.
module rr_select #(
  parameter  int NUM_CH = 8,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CW-1:0]     ptr,
  output logic [CW-1:0]     sel,
  output logic              found
);

  logic [CW-1:0] ix;

  // Scan farthest to nearest so the nearest hit is written last.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    ix    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      ix = CW'((int'(ptr) + i) % NUM_CH);
      if (mask[ix]) begin
        sel   = ix;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// ADC sequencer: rate divider, round-robin channel pick, one
// handshaked sample per tick. ADC_SCHED_OVERSAMPLE_EN: 4-sample average.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter  int NUM_CH = 8,
  parameter  int DIV_W  = 16,
  parameter  int DATA_W = ADC_DATA_W,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_req,
  output logic [CW-1:0]     adc_ch,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] s_data,
  output logic [CW-1:0]     s_ch,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  state_t             state, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [CW-1:0]      rr_ptr;
  logic [CW-1:0]      sel;
  logic               sel_found;
  logic               start;
  logic               capture;
  logic               release_s;
  logic               req_d;
  logic               last_conv;
  logic [DATA_W-1:0]  sample;

  // Count above a shrunken div_cfg also fires, so a new period applies at once.
  assign tick = enable && (div_cnt >= div_cfg);

  rr_select #(.NUM_CH(NUM_CH)) u_rr (
    .mask  (ch_mask),
    .ptr   (rr_ptr),
    .sel   (sel),
    .found (sel_found)
  );

`ifdef ADC_SCHED_OVERSAMPLE_EN
  localparam int OSW = $clog2(OVERSAMPLE_N);

  logic [OSW-1:0]        os_cnt;
  logic [DATA_W+OSW-1:0] acc;
  logic [DATA_W+OSW-1:0] acc_sum;

  assign acc_sum   = acc + (DATA_W+OSW)'(adc_data);
  assign sample    = acc_sum[DATA_W+OSW-1:OSW];
  assign last_conv = (os_cnt == OSW'(OVERSAMPLE_N - 1));

  // Burst accumulator, cleared whenever a new channel is picked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt <= '0;
      acc    <= '0;
    end else if (start) begin
      os_cnt <= '0;
      acc    <= '0;
    end else if (state == CONVERT && adc_done) begin
      os_cnt <= os_cnt + OSW'(1);
      acc    <= acc_sum;
    end
  end
`else
  assign sample    = adc_data;
  assign last_conv = 1'b1;
`endif

  // Rate divider: free-runs only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (!enable || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    capture   = 1'b0;
    release_s = 1'b0;
    req_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable)
          state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick && sel_found) begin
          start   = 1'b1;
          req_d   = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (adc_done) begin
          if (last_conv) begin
            capture = 1'b1;
            state_d = OUTPUT;
          end else begin
            req_d = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (s_ready) begin
          release_s = 1'b1;
          state_d   = enable ? WAIT_TICK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request pulse, channel hold, output register and rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_req <= 1'b0;
      adc_ch  <= '0;
      s_data  <= '0;
      s_ch    <= '0;
      s_valid <= 1'b0;
      rr_ptr  <= CW'(NUM_CH - 1);
    end else begin
      adc_req <= req_d;
      if (start)
        adc_ch <= sel;
      if (capture) begin
        s_data  <= sample;
        s_ch    <= adc_ch;
        s_valid <= 1'b1;
        rr_ptr  <= adc_ch;
      end else if (release_s) begin
        s_valid <= 1'b0;
      end
    end
  end

  // Sticky overrun on ticks that arrive while busy; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (overrun_clr)
      overrun <= 1'b0;
    else if (tick && (state == CONVERT || state == OUTPUT))
      overrun <= 1'b1;
  end

endmodule
